// File: rtl/sim_ctrl_pkg.sv
// Shared types and constants for the simulation-control monitor.
package sim_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_NONE     = 3'd0,
    ST_PASS     = 3'd1,
    ST_FAIL     = 3'd2,
    ST_EXIT_OK  = 3'd3,
    ST_EXIT_ERR = 3'd4,
    ST_TIMEOUT  = 3'd5,
    ST_HANG     = 3'd6
  } status_e;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [31:0] EXIT_CODE_FAIL      = 32'd1;
  localparam logic [31:0] EXIT_CODE_TIMEOUT   = 32'hFFFF_FFFF;
  localparam logic [31:0] EXIT_CODE_HANG_BASE = 32'hDEAD_0000;

endpackage

// File: rtl/sim_ctrl_arbiter.sv
// Lowest-index priority encoder: reports whether any request is set and
// the index of the lowest one.
module sim_ctrl_arbiter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  // Scan from the top so the lowest set request is the last one written.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_o = 1'b1;
        idx_o   = W'(i);
      end
    end
  end

endmodule

// File: rtl/sim_ctrl_monitor.sv
// Simulation-control monitor: sequences core reset release, counts run
// cycles against a limit and resolves per-channel pass/fail/exit reports
// into one sticky verdict.
// Optional idle (hang) watchdog: define SIM_CTRL_MONITOR_IDLE_WDT_EN.
//
// state  | meaning
// HOLD   | cores held in reset for RESET_WAIT_CYCLES, reports ignored
// RUN    | cores running, cycle counter live, reports resolved
// DONE   | verdict latched, everything frozen until restart or reset
module sim_ctrl_monitor
  import sim_ctrl_pkg::*;
#(
  parameter int NUM_CH            = 2,
  parameter int CNT_W             = 32,
  parameter int RESET_WAIT_CYCLES = 4,
  parameter int WAIT_ALL          = 1,
  parameter int IDLE_LIMIT        = 1024
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         soft_rst_req_i,
  input  logic [CNT_W-1:0]                             max_cycles_i,
  input  logic [NUM_CH-1:0]                            passed_i,
  input  logic [NUM_CH-1:0]                            failed_i,
  input  logic [NUM_CH-1:0]                            exit_valid_i,
  input  logic [NUM_CH*32-1:0]                         exit_value_i,
  input  logic [NUM_CH-1:0]                            retire_i,
  output logic                                         core_rst_no,
  output logic                                         done_o,
  output logic [2:0]                                   status_o,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] fail_ch_o,
  output logic [31:0]                                  exit_code_o,
  output logic [CNT_W-1:0]                             cycle_cnt_o
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int HOLD_W = (RESET_WAIT_CYCLES > 1) ? $clog2(RESET_WAIT_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_WAIT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0]  fin_q, fin_d;
  logic [NUM_CH-1:0]  xok_q, xok_d;
  logic               core_q, core_d;
  logic               done_q, done_d;
  status_e            status_q, status_d;
  logic [CH_W-1:0]    fail_ch_q, fail_ch_d;
  logic [31:0]        code_q, code_d;

  logic [NUM_CH-1:0]  exit_nz;
  logic [NUM_CH-1:0]  bad_now, ok_exit_now, ok_now;
  logic               bad_found, hang_found;
  logic [CH_W-1:0]    bad_idx, hang_idx;
  logic [31:0]        bad_value;
  logic               all_ok, via_exit, timeout;

  // Classify each channel's reports for this cycle.
  always_comb begin
    exit_nz = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      exit_nz[k] = |exit_value_i[32*k +: 32];
    end
  end

  assign bad_now     = failed_i | (exit_valid_i & exit_nz);
  assign ok_exit_now = exit_valid_i & ~exit_nz;
  assign ok_now      = passed_i | ok_exit_now;
  assign timeout     = (max_cycles_i != '0) && (cnt_q >= max_cycles_i);
  assign bad_value   = exit_value_i[32*int'(bad_idx) +: 32];

  // Completion test; an exit report anywhere among the contributors
  // downgrades the verdict from PASS to EXIT_OK.
  always_comb begin
    all_ok   = 1'b0;
    via_exit = 1'b0;
    if (WAIT_ALL != 0) begin
      all_ok   = &(fin_q | ok_now);
      via_exit = |(xok_q | ok_exit_now);
    end else begin
      all_ok   = |ok_now;
      via_exit = |ok_exit_now;
    end
  end

  sim_ctrl_arbiter #(.N(NUM_CH), .W(CH_W)) u_bad_arb (
    .req_i   (bad_now),
    .found_o (bad_found),
    .idx_o   (bad_idx)
  );

`ifdef SIM_CTRL_MONITOR_IDLE_WDT_EN
  localparam int IDLE_W = $clog2(IDLE_LIMIT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(IDLE_LIMIT);

  logic [IDLE_W-1:0] idle_q [NUM_CH];
  logic [IDLE_W-1:0] idle_d [NUM_CH];
  logic [NUM_CH-1:0] hang_vec;

  // Per-channel idle down-counters; reaching zero on an unfinished
  // channel flags a hang.
  always_comb begin
    hang_vec = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idle_d[k]   = idle_q[k];
      hang_vec[k] = ~fin_q[k] && (idle_q[k] == '0);
      if (soft_rst_req_i || state_q == S_HOLD) begin
        idle_d[k] = IDLE_LOAD;
      end else if (state_q == S_RUN) begin
        if (retire_i[k] || fin_q[k]) begin
          idle_d[k] = IDLE_LOAD;
        end else if (idle_q[k] != '0) begin
          idle_d[k] = idle_q[k] - IDLE_W'(1);
        end
      end
    end
  end

  // Idle counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) idle_q[k] <= IDLE_LOAD;
    end else begin
      for (int k = 0; k < NUM_CH; k++) idle_q[k] <= idle_d[k];
    end
  end

  sim_ctrl_arbiter #(.N(NUM_CH), .W(CH_W)) u_hang_arb (
    .req_i   (hang_vec),
    .found_o (hang_found),
    .idx_o   (hang_idx)
  );
`else
  logic unused_retire;
  assign unused_retire = ^{retire_i, (IDLE_LIMIT > 0)};
  assign hang_found    = 1'b0;
  assign hang_idx      = '0;
`endif

  // Next-state and verdict resolution.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    fin_d     = fin_q;
    xok_d     = xok_q;
    core_d    = core_q;
    done_d    = done_q;
    status_d  = status_q;
    fail_ch_d = fail_ch_q;
    code_d    = code_q;
    if (soft_rst_req_i) begin
      state_d   = S_HOLD;
      hold_d    = HOLD_LOAD;
      cnt_d     = '0;
      fin_d     = '0;
      xok_d     = '0;
      core_d    = 1'b0;
      done_d    = 1'b0;
      status_d  = ST_NONE;
      fail_ch_d = '0;
      code_d    = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (hold_q == '0) begin
            state_d = S_RUN;
            core_d  = 1'b1;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        S_RUN: begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          fin_d = fin_q | ok_now;
          xok_d = xok_q | ok_exit_now;
          if (bad_found) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            fail_ch_d = bad_idx;
            if (failed_i[bad_idx]) begin
              status_d = ST_FAIL;
              code_d   = EXIT_CODE_FAIL;
            end else begin
              status_d = ST_EXIT_ERR;
              code_d   = bad_value;
            end
          end else if (hang_found) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            status_d  = ST_HANG;
            fail_ch_d = hang_idx;
            code_d    = EXIT_CODE_HANG_BASE | 32'(hang_idx);
          end else if (timeout) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            status_d = ST_TIMEOUT;
            code_d   = EXIT_CODE_TIMEOUT;
          end else if (all_ok) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            status_d = via_exit ? ST_EXIT_OK : ST_PASS;
            code_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_HOLD;
      hold_q    <= HOLD_LOAD;
      cnt_q     <= '0;
      fin_q     <= '0;
      xok_q     <= '0;
      core_q    <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= ST_NONE;
      fail_ch_q <= '0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      fin_q     <= fin_d;
      xok_q     <= xok_d;
      core_q    <= core_d;
      done_q    <= done_d;
      status_q  <= status_d;
      fail_ch_q <= fail_ch_d;
      code_q    <= code_d;
    end
  end

  assign core_rst_no = core_q;
  assign done_o      = done_q;
  assign status_o    = status_q;
  assign fail_ch_o   = fail_ch_q;
  assign exit_code_o = code_q;
  assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_sim_ctrl_monitor.sv
// Bench for sim_ctrl_monitor: two instances (wait-all and first-finish)
// share one stimulus stream. Table vectors feed per-instance expected
// verdict queues that are popped when done_o rises; restart, async reset
// and (with SIM_CTRL_MONITOR_IDLE_WDT_EN) hang are hand sequences.
module tb_sim_ctrl_monitor;

  typedef struct {
    int         cyc;
    logic [1:0] pass;
    logic [1:0] fail;
    logic [1:0] xv;
    logic [31:0] v0;
    logic [31:0] v1;
  } ev_t;

  typedef struct {
    logic [2:0]  status;
    logic        ch;
    logic [31:0] code;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic [31:0] max_cyc;
    ev_t         a;
    ev_t         b;
    exp_t        e_wa;
    exp_t        e_any;
  } vec_t;

  localparam int NV  = 10;
  localparam int WIN = 60;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        soft_rst_req_i;
  logic [31:0] max_cycles_i;
  logic [1:0]  passed_i, failed_i, exit_valid_i, retire_i;
  logic [63:0] exit_value_i;

  logic        core_w   [2];
  logic        done_w   [2];
  logic [2:0]  status_w [2];
  logic        ch_w     [2];
  logic [31:0] code_w   [2];
  logic [31:0] cnt_w    [2];

  int checks = 0;
  int errors = 0;
  vec_t vecs [NV];
  exp_t q_wa [$];
  exp_t q_any [$];
  logic seen [2];

  always #5 clk = ~clk;

  sim_ctrl_monitor #(.NUM_CH(2), .CNT_W(32), .RESET_WAIT_CYCLES(4), .WAIT_ALL(1), .IDLE_LIMIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .soft_rst_req_i(soft_rst_req_i), .max_cycles_i(max_cycles_i),
    .passed_i(passed_i), .failed_i(failed_i), .exit_valid_i(exit_valid_i),
    .exit_value_i(exit_value_i), .retire_i(retire_i),
    .core_rst_no(core_w[0]), .done_o(done_w[0]), .status_o(status_w[0]),
    .fail_ch_o(ch_w[0]), .exit_code_o(code_w[0]), .cycle_cnt_o(cnt_w[0]));

  sim_ctrl_monitor #(.NUM_CH(2), .CNT_W(32), .RESET_WAIT_CYCLES(4), .WAIT_ALL(0), .IDLE_LIMIT(16)) dut_any (
    .clk(clk), .rst_n(rst_n), .soft_rst_req_i(soft_rst_req_i), .max_cycles_i(max_cycles_i),
    .passed_i(passed_i), .failed_i(failed_i), .exit_valid_i(exit_valid_i),
    .exit_value_i(exit_value_i), .retire_i(retire_i),
    .core_rst_no(core_w[1]), .done_o(done_w[1]), .status_o(status_w[1]),
    .fail_ch_o(ch_w[1]), .exit_code_o(code_w[1]), .cycle_cnt_o(cnt_w[1]));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk_ev(int cyc, logic [1:0] p, logic [1:0] f, logic [1:0] x,
                                logic [31:0] v0, logic [31:0] v1);
    ev_t e;
    e.cyc = cyc; e.pass = p; e.fail = f; e.xv = x; e.v0 = v0; e.v1 = v1;
    return e;
  endfunction

  function automatic exp_t mk_exp(logic [2:0] st, logic ch, logic [31:0] code, logic [31:0] cnt);
    exp_t e;
    e.status = st; e.ch = ch; e.code = code; e.cnt = cnt;
    return e;
  endfunction

  function automatic vec_t mk_vec(logic [31:0] mx, ev_t a, ev_t b, exp_t ewa, exp_t eany);
    vec_t v;
    v.max_cyc = mx; v.a = a; v.b = b; v.e_wa = ewa; v.e_any = eany;
    return v;
  endfunction

  task automatic clear_inputs();
    soft_rst_req_i = 1'b0;
    passed_i       = '0;
    failed_i       = '0;
    exit_valid_i   = '0;
    exit_value_i   = '0;
    retire_i       = 2'b11;
  endtask

  task automatic apply_ev(input ev_t e, input int c);
    if (e.cyc == c) begin
      passed_i     = passed_i | e.pass;
      failed_i     = failed_i | e.fail;
      exit_valid_i = exit_valid_i | e.xv;
      exit_value_i = {e.v1, e.v0};
    end
  endtask

  // Pulse restart and wait (bounded) for the cores to leave reset.
  task automatic do_soft_reset();
    clear_inputs();
    max_cycles_i   = '0;
    soft_rst_req_i = 1'b1;
    @(negedge clk);
    soft_rst_req_i = 1'b0;
    for (int k = 0; k < 12 && !core_w[0]; k++) @(negedge clk);
    check("run_entry", core_w[0], 1'b1);
  endtask

  task automatic score(input int d, input int i);
    exp_t e;
    if (done_w[d] && !seen[d]) begin
      seen[d] = 1'b1;
      if ((d == 0 ? q_wa.size() : q_any.size()) == 0) begin
        check($sformatf("vec%0d_dut%0d_spurious_done", i, d), 1'b1, 1'b0);
      end else begin
        e = (d == 0) ? q_wa.pop_front() : q_any.pop_front();
        check($sformatf("vec%0d_dut%0d_verdict", i, d),
              {status_w[d], ch_w[d], code_w[d], cnt_w[d]}, {e.status, e.ch, e.code, e.cnt});
      end
    end
  endtask

  task automatic run_vec(input int i);
    exp_t e;
    do_soft_reset();
    q_wa.push_back(vecs[i].e_wa);
    q_any.push_back(vecs[i].e_any);
    seen[0] = 1'b0;
    seen[1] = 1'b0;
    for (int c = 0; c < WIN; c++) begin
      score(0, i);
      score(1, i);
      clear_inputs();
      max_cycles_i = vecs[i].max_cyc;
      apply_ev(vecs[i].a, c);
      apply_ev(vecs[i].b, c);
      @(negedge clk);
    end
    clear_inputs();
    for (int d = 0; d < 2; d++) begin
      e = (d == 0) ? vecs[i].e_wa : vecs[i].e_any;
      check($sformatf("vec%0d_dut%0d_frozen", i, d),
            {done_w[d], status_w[d], ch_w[d], code_w[d], cnt_w[d]},
            {1'b1, e.status, e.ch, e.code, e.cnt});
    end
    if (q_wa.size() != 0) check($sformatf("vec%0d_dut0_no_done", i), 1'b0, 1'b1);
    if (q_any.size() != 0) check($sformatf("vec%0d_dut1_no_done", i), 1'b0, 1'b1);
    q_wa.delete();
    q_any.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    ev_t none;
    int n;
    none = mk_ev(-1, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
    vecs[0] = mk_vec(0,  mk_ev(10, 2'b01, 2'b00, 2'b00, 0, 0), mk_ev(20, 2'b10, 2'b00, 2'b00, 0, 0),
                     mk_exp(3'd1, 1'b0, 32'd0, 32'd21), mk_exp(3'd1, 1'b0, 32'd0, 32'd11));
    vecs[1] = mk_vec(0,  mk_ev(5, 2'b01, 2'b00, 2'b10, 0, 7), none,
                     mk_exp(3'd4, 1'b1, 32'd7, 32'd6), mk_exp(3'd4, 1'b1, 32'd7, 32'd6));
    vecs[2] = mk_vec(50, none, none,
                     mk_exp(3'd5, 1'b0, 32'hFFFF_FFFF, 32'd51), mk_exp(3'd5, 1'b0, 32'hFFFF_FFFF, 32'd51));
    vecs[3] = mk_vec(50, mk_ev(50, 2'b00, 2'b01, 2'b00, 0, 0), none,
                     mk_exp(3'd2, 1'b0, 32'd1, 32'd51), mk_exp(3'd2, 1'b0, 32'd1, 32'd51));
    vecs[4] = mk_vec(0,  mk_ev(3, 2'b00, 2'b00, 2'b01, 0, 0), mk_ev(6, 2'b00, 2'b10, 2'b00, 0, 0),
                     mk_exp(3'd2, 1'b1, 32'd1, 32'd7), mk_exp(3'd3, 1'b0, 32'd0, 32'd4));
    vecs[5] = mk_vec(0,  mk_ev(4, 2'b00, 2'b00, 2'b01, 0, 0), mk_ev(9, 2'b10, 2'b00, 2'b00, 0, 0),
                     mk_exp(3'd3, 1'b0, 32'd0, 32'd10), mk_exp(3'd3, 1'b0, 32'd0, 32'd5));
    vecs[6] = mk_vec(0,  mk_ev(7, 2'b01, 2'b01, 2'b00, 0, 0), none,
                     mk_exp(3'd2, 1'b0, 32'd1, 32'd8), mk_exp(3'd2, 1'b0, 32'd1, 32'd8));
    vecs[7] = mk_vec(0,  mk_ev(12, 2'b00, 2'b10, 2'b01, 5, 0), none,
                     mk_exp(3'd4, 1'b0, 32'd5, 32'd13), mk_exp(3'd4, 1'b0, 32'd5, 32'd13));
    vecs[8] = mk_vec(30, mk_ev(10, 2'b01, 2'b00, 2'b00, 0, 0), mk_ev(30, 2'b10, 2'b00, 2'b00, 0, 0),
                     mk_exp(3'd5, 1'b0, 32'hFFFF_FFFF, 32'd31), mk_exp(3'd1, 1'b0, 32'd0, 32'd11));
    vecs[9] = mk_vec(0,  mk_ev(15, 2'b11, 2'b00, 2'b00, 0, 0), none,
                     mk_exp(3'd1, 1'b0, 32'd0, 32'd16), mk_exp(3'd1, 1'b0, 32'd0, 32'd16));

    // Power-on reset and release timing.
    clear_inputs();
    max_cycles_i = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {core_w[0], done_w[0], status_w[0], ch_w[0], code_w[0], cnt_w[0]}, '0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_cycle3", core_w[0], 1'b0);
    @(negedge clk);
    check("hold_cycle4_release", {core_w[0], core_w[1], cnt_w[0]}, {1'b1, 1'b1, 32'd0});

    for (int i = 0; i < NV; i++) run_vec(i);

    // Restart mid-run clears counters, verdicts and sticky finishes.
    do_soft_reset();
    for (int c = 0; c <= 8; c++) begin
      clear_inputs();
      if (c == 3) passed_i = 2'b01;
      if (c == 8) soft_rst_req_i = 1'b1;
      @(negedge clk);
    end
    clear_inputs();
    check("restart_cleared", {core_w[0], cnt_w[0], done_w[1], status_w[1]}, '0);
    n = 0;
    while (!core_w[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("restart_hold_len", n, 4);
    for (int c = 0; c < 20; c++) begin
      if (c == 10) check("restart_fin_cleared", done_w[0], 1'b0);
      clear_inputs();
      if (c == 5) passed_i = 2'b10;
      if (c == 12) passed_i = 2'b01;
      @(negedge clk);
    end
    check("restart_pass", {done_w[0], status_w[0], code_w[0], cnt_w[0]}, {1'b1, 3'd1, 32'd0, 32'd13});

`ifdef SIM_CTRL_MONITOR_IDLE_WDT_EN
    // Channel 1 never retires: watchdog should flag it.
    do_soft_reset();
    for (int c = 0; c < 30; c++) begin
      clear_inputs();
      retire_i = 2'b01;
      @(negedge clk);
    end
    clear_inputs();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("hang_dut%0d", d), {done_w[d], status_w[d], ch_w[d], code_w[d], cnt_w[d]},
            {1'b1, 3'd6, 1'b1, 32'hDEAD_0001, 32'd17});
    end
`endif

    // Asynchronous reset mid-run takes effect without a clock edge.
    do_soft_reset();
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {core_w[0], done_w[0], cnt_w[0]}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sim_ctrl_monitor.md
Name: sim_ctrl_monitor

Overview:
- Synthesisable simulation-control block for multi-hart RI5CY subsystem benches.
- Sequences core reset release and counts cycles against a runtime limit.
- Collects pass/fail/exit reports from NUM_CH channels and resolves them into one sticky verdict, which the bench top polls to end simulation.
- Generalises the single-core, single-verdict bench logic to N channels, wait-all mode, restart and hang detection.

Parameters:
NUM_CH, 2, number of reporting channels (harts/subsystems), >=1
CNT_W, 32, cycle counter width
RESET_WAIT_CYCLES, 4, cycles core_rst_no is held low after reset/restart, >=1
WAIT_ALL, 1, 1: pass only when every channel finished OK; 0: first OK finish ends run
IDLE_LIMIT, 1024, hang watchdog threshold in cycles (used only with optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
soft_rst_req_i  in  1  restart request, single-cycle pulse
max_cycles_i  in  CNT_W  run-cycle limit; 0 = unlimited
passed_i  in  NUM_CH  per-channel tests-passed pulse
failed_i  in  NUM_CH  per-channel tests-failed pulse
exit_valid_i  in  NUM_CH  per-channel exit report valid
exit_value_i  in  NUM_CH*32  per-channel exit value; channel k at [32k+31:32k]
retire_i  in  NUM_CH  per-channel instruction-retired pulse
core_rst_no  out  1  active-low reset to cores, registered
done_o  out  1  verdict valid, sticky
status_o  out  3  0 NONE, 1 PASS, 2 FAIL, 3 EXIT_OK, 4 EXIT_ERR, 5 TIMEOUT, 6 HANG
fail_ch_o  out  max(1,$clog2(NUM_CH))  channel causing FAIL/EXIT_ERR/HANG
exit_code_o  out  32  verdict code
cycle_cnt_o  out  CNT_W  cycles spent in RUN

Behaviour:
- Reset is rst_n (asynchronous, active-low) on clock clk.
- Reset values: core_rst_no=0, done_o=0, status_o=0, fail_ch_o=0, exit_code_o=0, cycle_cnt_o=0, fin_q=0, FSM=HOLD.
- HOLD:
  - Hold counter counts RESET_WAIT_CYCLES cycles; all report inputs are ignored.
  - On the last count, core_rst_no rises on the next edge and the FSM enters RUN.
- RUN:
  - cycle_cnt_o increments every cycle and saturates at all-ones.
  - Per channel, OK-finish = passed_i, or exit_valid_i with value 0. It sets sticky fin_q[k].
  - Per channel, bad-finish = failed_i, or exit_valid_i with nonzero value.
- Verdict priority within one cycle, highest first:
  - bad-finish on any channel: lowest-index bad channel wins. failed_i gives FAIL with exit_code 1; otherwise EXIT_ERR with exit_code = that channel's value.
  - Timeout: max_cycles_i!=0 and cycle_cnt_o>=max_cycles_i gives TIMEOUT, exit_code 32'hFFFF_FFFF.
  - All OK: WAIT_ALL=1 requires (fin_q | ok_now) all-ones; WAIT_ALL=0 requires any ok_now. If every contributing report was passed_i the verdict is PASS, else EXIT_OK; exit_code 0.
- Simultaneous passed_i and failed_i on one channel counts as bad.
- Verdict outputs register one cycle after the triggering input edge. The FSM enters DONE and done_o=1 in that same cycle.
- DONE:
  - All outputs frozen; inputs ignored; cycle_cnt_o stops; core_rst_no stays 1.
- soft_rst_req_i in any state, at the next edge:
  - core_rst_no=0, and all outputs, fin_q and counters clear to reset values.
  - FSM returns to HOLD. The full RESET_WAIT_CYCLES hold repeats.
- Assertion of rst_n mid-run aborts immediately to reset values.

Optional Feature:
- Macro SIM_CTRL_MONITOR_IDLE_WDT_EN.
- Defined:
  - A per-channel idle counter runs in RUN. It clears on retire_i[k] or when fin_q[k] is set.
  - If an unfinished channel's counter reaches IDLE_LIMIT, the verdict is HANG, fail_ch_o = lowest such channel, exit_code 32'hDEAD_0000|k.
  - HANG priority sits below bad-finish and above TIMEOUT.
- Undefined:
  - retire_i is unused, no idle counters exist, and status 6 is never produced.

Decomposition:
- Package sim_ctrl_pkg holds:
  - the status_e enum (3-bit codes above) and the FSM state enum (HOLD/RUN/DONE);
  - constants EXIT_CODE_FAIL=1, EXIT_CODE_TIMEOUT=32'hFFFF_FFFF, EXIT_CODE_HANG_BASE=32'hDEAD_0000.
- One natural sub-module, sim_ctrl_arbiter: a combinational lowest-index priority encoder returning the found flag and index. It is instantiated for the bad-finish vector and the hang vector.

Test Plan:
- NUM_CH=2, WAIT_ALL=1, max_cycles 0:
  - Reset release is checked after 4 cycles.
  - passed_i[0] at RUN cycle 10, passed_i[1] at cycle 20 -> done_o at cycle 21, status PASS, exit_code 0, cycle_cnt_o=21.
- exit_valid_i[1] with value 7 at cycle 5 and passed_i[0] in the same cycle -> status EXIT_ERR, fail_ch_o=1, exit_code 7.
- max_cycles_i=50 with no reports -> status TIMEOUT at cnt 50, exit_code FFFF_FFFF. A failed_i[0] at the cycle cnt hits 50 gives FAIL instead.
- WAIT_ALL=0: exit_valid_i[0] with value 0 at cycle 3 -> EXIT_OK; later failed_i[1] is ignored and outputs stay frozen.
- soft_rst_req_i during RUN at cycle 8 -> core_rst_no low next cycle and high again 4 cycles later; counters restart from 0; an earlier fin_q[0] is cleared.
- With SIM_CTRL_MONITOR_IDLE_WDT_EN, IDLE_LIMIT=16: retire_i[1] stuck at 0 and channel 0 retiring -> HANG, fail_ch_o=1, exit_code DEAD_0001.
